// File: rtl/jogo_pkg.sv
// Shared state encodings and debug-display width for the game datapath.
// Also used by circuito_jogo; keep codes stable for the 7-segment decoder.
package jogo_pkg;

  localparam int DB_ESTADO_W = 4;

  localparam logic [2:0] OCIOSO     = 3'd0;
  localparam logic [2:0] ESPERA     = 3'd1;
  localparam logic [2:0] ESTABILIZA = 3'd2;
  localparam logic [2:0] REGISTRA   = 3'd3;
  localparam logic [2:0] SOLTA      = 3'd4;

  // True when exactly one bit of the (zero-extended) button vector is set.
  function automatic logic eh_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-MODULO cycle counter with synchronous clear, enable and a
// terminal-count flag; wraps to zero after the terminal value.
module contador_m #(
  parameter int MODULO = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = (MODULO > 1) ? $clog2(MODULO) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

  assign terminal = (count == W'(MODULO - 1));

endmodule

// File: rtl/detector_jogada.sv
// Debounced single-button play detector with hold/acknowledge handshake.
// Define DETECTOR_JOGADA_TIMEOUT_EN to compile in the ESPERA idle timeout.
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int N_BOTOES        = 9,
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int TIMEOUT_CICLOS  = 1000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        habilita,
  input  logic [N_BOTOES-1:0]         botoes,
  input  logic                        consome,
  output logic                        jogada_valida,
  output logic [$clog2(N_BOTOES)-1:0] jogada_idx,
  output logic [N_BOTOES-1:0]         jogada_onehot,
  output logic                        erro_multipla,
  output logic                        timeout,
  output logic [DB_ESTADO_W-1:0]      db_estado
);

  localparam int IDX_W = $clog2(N_BOTOES);

  logic [2:0]          estado, estado_next;
  logic [N_BOTOES-1:0] snapshot, snapshot_next;
  logic [IDX_W-1:0]    idx_enc;
  logic                db_enable, db_terminal;
  logic                erro_next;

  // One counter serves both press stabilisation and release detection;
  // it is cleared whenever the stability condition of the state breaks.
  contador_m #(.MODULO(DEBOUNCE_CICLOS)) u_debounce (
    .clock    (clock),
    .reset    (reset),
    .clear    (!db_enable),
    .enable   (db_enable),
    .terminal (db_terminal)
  );

  always_comb begin
    estado_next   = estado;
    snapshot_next = snapshot;
    db_enable     = 1'b0;
    erro_next     = 1'b0;
    case (estado)
      OCIOSO: begin
        if (habilita) estado_next = ESPERA;
      end
      ESPERA: begin
        if (!habilita) begin
          estado_next = OCIOSO;
        end else if (botoes != '0) begin
          snapshot_next = botoes;
          estado_next   = ESTABILIZA;
        end
      end
      ESTABILIZA: begin
        if (!habilita) begin
          estado_next = OCIOSO;
        end else if (botoes == '0) begin
          estado_next = ESPERA;
        end else if (botoes != snapshot) begin
          snapshot_next = botoes;
        end else begin
          db_enable = 1'b1;
          if (db_terminal) begin
            if (eh_onehot(16'(snapshot))) begin
              estado_next = REGISTRA;
            end else begin
              erro_next   = 1'b1;
              estado_next = SOLTA;
            end
          end
        end
      end
      REGISTRA: begin
        if (consome) estado_next = SOLTA;
      end
      SOLTA: begin
        if (botoes == '0) begin
          db_enable = 1'b1;
          if (db_terminal) estado_next = habilita ? ESPERA : OCIOSO;
        end
      end
      default: estado_next = OCIOSO;
    endcase
  end

  always_comb begin
    idx_enc = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      if (snapshot[i]) idx_enc = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= OCIOSO;
      snapshot      <= '0;
      jogada_idx    <= '0;
      jogada_onehot <= '0;
      erro_multipla <= 1'b0;
    end else begin
      estado        <= estado_next;
      snapshot      <= snapshot_next;
      erro_multipla <= erro_next;
      if (estado_next == REGISTRA && estado != REGISTRA) begin
        jogada_idx    <= idx_enc;
        jogada_onehot <= snapshot;
      end
    end
  end

  assign jogada_valida = (estado == REGISTRA);
  assign db_estado     = DB_ESTADO_W'(estado);

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
  logic to_enable, to_terminal, timeout_q;

  // Only uninterrupted residence in ESPERA counts toward the timeout.
  assign to_enable = (estado == ESPERA) && (estado_next == ESPERA);

  contador_m #(.MODULO(TIMEOUT_CICLOS)) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (!to_enable),
    .enable   (to_enable),
    .terminal (to_terminal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= to_enable && to_terminal;
  end

  assign timeout = timeout_q;
`else
  // Timeout feature absent: output tied low, parameter kept for interface compatibility.
  assign timeout = (TIMEOUT_CICLOS < 1) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with a play scoreboard.
// Define DETECTOR_JOGADA_TIMEOUT_EN to check the timeout pulses as well.
module tb_detector_jogada;

  typedef struct {
    logic [3:0] idx;
    logic [8:0] onehot;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [8:0] botoes;
  logic       consome;
  logic       jogada_valida;
  logic [3:0] jogada_idx;
  logic [8:0] jogada_onehot;
  logic       erro_multipla;
  logic       timeout;
  logic [3:0] db_estado;

  int   checks = 0;
  int   errors = 0;
  int   rises  = 0;
  exp_t sb[$];
  exp_t e_mon;
  logic valid_prev = 1'b0;

  detector_jogada #(
    .N_BOTOES        (9),
    .DEBOUNCE_CICLOS (4),
    .TIMEOUT_CICLOS  (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .habilita      (habilita),
    .botoes        (botoes),
    .consome       (consome),
    .jogada_valida (jogada_valida),
    .jogada_idx    (jogada_idx),
    .jogada_onehot (jogada_onehot),
    .erro_multipla (erro_multipla),
    .timeout       (timeout),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every rising edge of jogada_valida consumes one expected play.
  always @(negedge clock) begin
    if (jogada_valida && !valid_prev) begin
      rises++;
      check("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e_mon = sb.pop_front();
        check("sb_idx", 32'(jogada_idx), 32'(e_mon.idx));
        check("sb_onehot", 32'(jogada_onehot), 32'(e_mon.onehot));
        $display("play: idx=%0d onehot=%b (expected idx=%0d onehot=%b)",
                 jogada_idx, jogada_onehot, e_mon.idx, e_mon.onehot);
      end
    end
    valid_prev = jogada_valida;
  end

  initial begin
    int erro_n;
    int pulses;
    int first;

    reset = 1'b1; habilita = 1'b0; botoes = '0; consome = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(jogada_valida), 0);
    check("rst_idx", 32'(jogada_idx), 0);
    check("rst_onehot", 32'(jogada_onehot), 0);
    check("rst_erro", 32'(erro_multipla), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_db", 32'(db_estado), 0);
    reset = 1'b0;

    // Single clean press, acknowledged at cycle 8, then release.
    habilita = 1'b1;
    tick();
    check("t1_espera", 32'(db_estado), 1);
    sb.push_back('{4'd3, 9'b000001000});
    botoes = 9'b000001000;
    for (int k = 1; k <= 20; k++) begin
      consome = (k == 8);
      tick();
      check($sformatf("t1_valid_k%0d", k), 32'(jogada_valida), 32'(k >= 5 && k <= 7));
      check($sformatf("t1_db_k%0d", k), 32'(db_estado),
            (k <= 4) ? 2 : (k <= 7) ? 3 : 4);
      if (k == 5) begin
        check("t1_idx", 32'(jogada_idx), 3);
        check("t1_onehot", 32'(jogada_onehot), 32'h008);
      end
    end
    consome = 1'b0;
    botoes  = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("t1_rel_db_k%0d", k), 32'(db_estado), (k < 4) ? 4 : 1);
    end
    check("t1_idx_hold", 32'(jogada_idx), 3);

    // Short glitchy presses never reach the debounce threshold.
    for (int r = 0; r < 4; r++) begin
      botoes = 9'b000010000;
      tick(); check("t2_glitch_valid_a", 32'(jogada_valida), 0);
      tick(); check("t2_glitch_valid_b", 32'(jogada_valida), 0);
      botoes = '0;
      tick(); check("t2_glitch_db", 32'(db_estado), 1);
    end
    sb.push_back('{4'd4, 9'b000010000});
    botoes = 9'b000010000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t2_valid_k%0d", k), 32'(jogada_valida), 32'(k >= 5));
    end
    check("t2_idx", 32'(jogada_idx), 4);
    consome = 1'b1;
    tick();
    consome = 1'b0;
    check("t2_ack_valid", 32'(jogada_valida), 0);
    check("t2_ack_db", 32'(db_estado), 4);
    botoes = '0;
    repeat (4) tick();
    check("t2_rel_db", 32'(db_estado), 1);

    // Two buttons held together: single error pulse, no play.
    erro_n = 0;
    botoes = 9'b000000011;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (erro_multipla) erro_n++;
      check($sformatf("t3_valid_k%0d", k), 32'(jogada_valida), 0);
      if (k == 5) check("t3_erro_at5", 32'(erro_multipla), 1);
    end
    check("t3_erro_count", 32'(erro_n), 1);
    check("t3_db_solta", 32'(db_estado), 4);
    repeat (2) tick();
    check("t3_db_held", 32'(db_estado), 4);
    check("t3_erro_low", 32'(erro_multipla), 0);
    botoes = '0;
    repeat (4) tick();
    check("t3_rel_db", 32'(db_estado), 1);

    // Held play survives habilita=0; async reset discards it.
    sb.push_back('{4'd0, 9'b000000001});
    botoes = 9'b000000001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("t4_valid_k%0d", k), 32'(jogada_valida), 32'(k == 5));
    end
    habilita = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("t4_hold_k%0d", k), 32'(jogada_valida), 1);
    end
    check("t4_db_hold", 32'(db_estado), 3);
    reset = 1'b1;
    #1;
    check("t4_rst_valid", 32'(jogada_valida), 0);
    check("t4_rst_idx", 32'(jogada_idx), 0);
    check("t4_rst_onehot", 32'(jogada_onehot), 0);
    check("t4_rst_db", 32'(db_estado), 0);
    check("t4_rst_timeout", 32'(timeout), 0);
    tick();
    reset  = 1'b0;
    botoes = '0;
    consome = 1'b1;
    tick();
    consome = 1'b0;
    check("t4_ocioso_db", 32'(db_estado), 0);

    // Idle in ESPERA with no buttons.
    habilita = 1'b1;
    tick();
    check("t5_espera", 32'(db_estado), 1);
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (timeout) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    check("t5_db", 32'(db_estado), 1);
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    check("t5_timeout_pulses", 32'(pulses), 3);
    check("t5_timeout_first", 32'(first), 10);
`else
    check("t5_timeout_pulses", 32'(pulses), 0);
`endif

    check("sb_drained", 32'(sb.size()), 0);
    check("sb_rises", 32'(rises), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
